// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - sequencer computing C = A x B through a one-cycle-latency memory port
module matmul_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_A,
    S_ADDR_B,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]  n_q, n_d;
  logic [DIM_W-1:0]  i_q, i_d;
  logic [DIM_W-1:0]  j_q, j_d;
  logic [DIM_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] ba_q, ba_d;
  logic [ADDR_W-1:0] bb_q, bb_d;
  logic [ADDR_W-1:0] bc_q, bc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] a_reg_q, a_reg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DIM_W-1:0]  n_m1;
  logic              k_last, j_last, i_last;
  logic [DATA_W-1:0] mac_sum;

  // Row-major element address; the product and sums wrap at ADDR_W bits,
  // which matches computing row*n at full width and truncating the final sum.
  function automatic logic [ADDR_W-1:0] mat_addr(
    input logic [ADDR_W-1:0] base,
    input logic [DIM_W-1:0]  row,
    input logic [DIM_W-1:0]  col,
    input logic [DIM_W-1:0]  n
  );
    return base + ADDR_W'(row) * ADDR_W'(n) + ADDR_W'(col);
  endfunction

  assign n_m1   = n_q - DIM_W'(1);
  assign k_last = (k_q == n_m1);
  assign j_last = (j_q == n_m1);
  assign i_last = (i_q == n_m1);

  // The low DATA_W bits of a product do not depend on operand signedness,
  // so an unsigned multiply gives the truncated signed result directly.
  assign mac_sum = acc_q + a_reg_q * mem_q;

  // Next-state and registered-output values: each output is computed for the state being entered.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    ba_d    = ba_q;
    bb_d    = bb_q;
    bc_d    = bc_q;
    acc_d   = acc_q;
    a_reg_d = a_reg_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dim != '0) begin
            n_d     = dim;
            ba_d    = base_a;
            bb_d    = base_b;
            bc_d    = base_c;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            addr_d  = base_a;
            state_d = S_ADDR_A;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ADDR_A: begin
        addr_d  = mat_addr(bb_q, k_q, j_q, n_q);
        state_d = S_ADDR_B;
      end
      S_ADDR_B: begin
        a_reg_d = mem_q;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = mac_sum;
        if (!k_last) begin
          k_d     = k_q + DIM_W'(1);
          addr_d  = mat_addr(ba_q, i_q, k_q + DIM_W'(1), n_q);
          state_d = S_ADDR_A;
        end else begin
          k_d     = '0;
          addr_d  = mat_addr(bc_q, i_q, j_q, n_q);
          wdata_d = mac_sum;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        acc_d = '0;
        if (!j_last) begin
          j_d     = j_q + DIM_W'(1);
          addr_d  = mat_addr(ba_q, i_q, '0, n_q);
          state_d = S_ADDR_A;
        end else if (!i_last) begin
          j_d     = '0;
          i_d     = i_q + DIM_W'(1);
          addr_d  = mat_addr(ba_q, i_q + DIM_W'(1), '0, n_q);
          state_d = S_ADDR_A;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ADDR_A) || (state_d == S_ADDR_B) ||
             (state_d == S_MAC)    || (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    wren_d = (state_d == S_WRITE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      bc_q    <= '0;
      acc_q   <= '0;
      a_reg_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      ba_q    <= ba_d;
      bb_q    <= bb_d;
      bc_q    <= bc_d;
      acc_q   <= acc_d;
      a_reg_q <= a_reg_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_address = addr_q;
  assign mem_data    = wdata_q;
  assign mem_wren    = wren_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - directed self-checking bench for matmul_sequencer
module tb_matmul_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  dim = 8'd0;
  logic [15:0] base_a = 16'd0;
  logic [15:0] base_b = 16'd0;
  logic [15:0] base_c = 16'd0;
  logic        busy;
  logic        done;
  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  logic        tb_we = 1'b0;
  logic [7:0]  tb_addr = 8'd0;
  logic [31:0] tb_data = 32'd0;
  logic [31:0] mem [0:255];

  int total = 0;
  int bad = 0;

  int busy_cnt = 0;
  int done_cnt = 0;
  int wren_cnt = 0;
  int consec_cnt = 0;
  logic prev_wren = 1'b0;
  logic [15:0] last_wr_addr = 16'd0;

  int s_busy, s_done, s_wren;
  bit ok;

  localparam logic [31:0] SENT = 32'hDEADBEEF;

  matmul_sequencer #(.ADDR_W(16), .DATA_W(32), .DIM_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .dim(dim),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy), .done(done),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // one-cycle-latency memory model; bench preload port has priority
  always @(posedge clock) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_wren) mem[mem_address[7:0]] <= mem_data;
    mem_q <= mem[mem_address[7:0]];
  end

  // activity counters sampled on the falling edge
  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (mem_wren) begin
      wren_cnt++;
      last_wr_addr = mem_address;
      if (prev_wren) consec_cnt++;
    end
    prev_wren = mem_wren;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] a, input logic [31:0] d);
    tb_we = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  task automatic snap();
    s_busy = busy_cnt;
    s_done = done_cnt;
    s_wren = wren_cnt;
  endtask

  task automatic start_job(input logic [7:0] n, input logic [15:0] ba, input logic [15:0] bb,
                           input logic [15:0] bc);
    @(negedge clock);
    dim = n; base_a = ba; base_b = bb; base_c = bc; start = 1'b1;
    @(negedge clock);
    start = 1'b0; dim = 8'hFF; base_a = 16'hFFFF; base_b = 16'hFFFF; base_c = 16'hFFFF;
  endtask

  task automatic wait_done(input int limit, output bit hit);
    hit = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (done) begin
        hit = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic load_job1();
    put(8'd0, 32'd1); put(8'd1, 32'd0); put(8'd2, 32'd0); put(8'd3, 32'd1);
    put(8'd16, 32'd1); put(8'd17, 32'd2); put(8'd18, 32'd3); put(8'd19, 32'd4);
    for (int a = 32; a < 36; a++) put(8'(a), SENT);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_wren", {31'b0, mem_wren}, 32'd0);
    check("rst_addr", {16'b0, mem_address}, 32'd0);
    check("rst_data", mem_data, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: N=2, A=I, B=[[1,2],[3,4]]
    load_job1();
    snap();
    start_job(8'd2, 16'd0, 16'd16, 16'd32);
    check("t1_busy_rise", {31'b0, busy}, 32'd1);
    wait_done(200, ok);
    check("t1_done_seen", {31'b0, ok}, 32'd1);
    check("t1_busy_at_done", {31'b0, busy}, 32'd0);
    @(negedge clock);
    check("t1_done_pulse", {31'b0, done}, 32'd0);
    @(negedge clock);
    check("t1_c00", mem[32], 32'd1);
    check("t1_c01", mem[33], 32'd2);
    check("t1_c10", mem[34], 32'd3);
    check("t1_c11", mem[35], 32'd4);
    check("t1_busy_cycles", busy_cnt - s_busy, 32'd28);
    check("t1_done_count", done_cnt - s_done, 32'd1);
    check("t1_wren_count", wren_cnt - s_wren, 32'd4);
    check("t1_last_wr_addr", {16'b0, last_wr_addr}, 32'd35);

    // 2: N=1, 7 * -3
    put(8'h40, 32'd7); put(8'h41, 32'hFFFFFFFD); put(8'h50, SENT);
    snap();
    start_job(8'd1, 16'h40, 16'h41, 16'h50);
    wait_done(50, ok);
    check("t2_done_seen", {31'b0, ok}, 32'd1);
    @(negedge clock);
    check("t2_c", mem[8'h50], 32'hFFFFFFEB);
    check("t2_busy_cycles", busy_cnt - s_busy, 32'd4);
    check("t2_wr_addr", {16'b0, last_wr_addr}, 32'h50);

    // 3: accumulation wrap
    put(8'h60, 32'h7FFFFFFF); put(8'h61, 32'd1); put(8'h62, 32'd0); put(8'h63, 32'd0);
    put(8'h70, 32'd2); put(8'h71, 32'd0); put(8'h72, 32'd1); put(8'h73, 32'd0);
    for (int a = 8'h80; a < 8'h84; a++) put(8'(a), SENT);
    start_job(8'd2, 16'h60, 16'h70, 16'h80);
    wait_done(200, ok);
    check("t3_done_seen", {31'b0, ok}, 32'd1);
    @(negedge clock);
    check("t3_c00", mem[8'h80], 32'hFFFFFFFF);
    check("t3_c01", mem[8'h81], 32'd0);
    check("t3_c10", mem[8'h82], 32'd0);
    check("t3_c11", mem[8'h83], 32'd0);

    // 4: dim = 0
    snap();
    start_job(8'd0, 16'h0, 16'h0, 16'h0);
    check("t4_done_high", {31'b0, done}, 32'd1);
    check("t4_busy_low", {31'b0, busy}, 32'd0);
    @(negedge clock);
    check("t4_done_low", {31'b0, done}, 32'd0);
    repeat (3) @(negedge clock);
    check("t4_busy_cycles", busy_cnt - s_busy, 32'd0);
    check("t4_wren_count", wren_cnt - s_wren, 32'd0);
    check("t4_done_count", done_cnt - s_done, 32'd1);

    // 5: reset during MAC of element (1,0), N=3
    put(8'h90, 32'd1); put(8'h91, 32'd2); put(8'h92, 32'd3);
    put(8'h93, 32'd4); put(8'h94, 32'd5); put(8'h95, 32'd6);
    put(8'h96, 32'd7); put(8'h97, 32'd8); put(8'h98, 32'd9);
    put(8'hA0, 32'd1); put(8'hA1, 32'd1); put(8'hA2, 32'd0);
    put(8'hA3, 32'd0); put(8'hA4, 32'd1); put(8'hA5, 32'd1);
    put(8'hA6, 32'd1); put(8'hA7, 32'd0); put(8'hA8, 32'd1);
    for (int a = 8'hB0; a < 8'hB9; a++) put(8'(a), SENT);
    snap();
    start_job(8'd3, 16'h90, 16'hA0, 16'hB0);
    repeat (32) @(negedge clock);
    check("t5_busy_in_mac", {31'b0, busy}, 32'd1);
    check("t5_wren_before", wren_cnt - s_wren, 32'd3);
    reset = 1'b1;
    @(negedge clock);
    check("t5_busy_rst", {31'b0, busy}, 32'd0);
    check("t5_wren_rst", {31'b0, mem_wren}, 32'd0);
    check("t5_done_rst", {31'b0, done}, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("t5_wren_after", wren_cnt - s_wren, 32'd3);
    check("t5_done_count", done_cnt - s_done, 32'd0);
    check("t5_c00", mem[8'hB0], 32'd4);
    check("t5_c01", mem[8'hB1], 32'd3);
    check("t5_c02", mem[8'hB2], 32'd5);
    for (int a = 8'hB3; a < 8'hB9; a++) check("t5_c_untouched", mem[8'(a)], SENT);

    // 6: start re-asserted while busy and during DONE
    load_job1();
    snap();
    start_job(8'd2, 16'd0, 16'd16, 16'd32);
    start = 1'b1; dim = 8'd3; base_a = 16'd16; base_b = 16'd0; base_c = 16'd0;
    repeat (5) @(negedge clock);
    start = 1'b0;
    wait_done(200, ok);
    check("t6_done_seen", {31'b0, ok}, 32'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("t6_idle_after_done", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clock);
    check("t6_stays_idle", {31'b0, busy}, 32'd0);
    check("t6_c00", mem[32], 32'd1);
    check("t6_c01", mem[33], 32'd2);
    check("t6_c10", mem[34], 32'd3);
    check("t6_c11", mem[35], 32'd4);
    check("t6_a00_intact", mem[0], 32'd1);
    check("t6_busy_cycles", busy_cnt - s_busy, 32'd28);
    check("t6_done_count", done_cnt - s_done, 32'd1);
    check("t6_wren_count", wren_cnt - s_wren, 32'd4);
    check("no_consec_writes", consec_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
